even_mult: RTL and testbench
============================

// Module: even_mult
// PURPOSE
//   Single-purpose processor (FSM + datapath) that computes the product of all even
//   integers 2,4,...,N_MAX. Multiplication uses a sequential shift-add unit.
//   A go_i pulse starts a run; done flags completion with result valid.
//   Standalone top in the SPP design; driven by a testbench or a host controller.
// PARAMETERS
//   N_MAX  12  Upper bound of the even-number sequence (inclusive), 0..2**IW-2
//   W      16  Accumulator/result width; product is truncated modulo 2**W
//   IW      8  Loop-index width; also the number of shift-add cycles per multiply
// PORTS
//   clk     in   1  Rising-edge clock, single clock domain
//   reset   in   1  Asynchronous, active-low reset (0 = reset)
//   go_i    in   1  Start request, sampled on rising edge; only honoured in IDLE or DONE
//   result  out  W  Accumulator contents; the final product while done=1
//   done    out  1  High while in DONE; registered
// BEHAVIOUR
//   Reset (async, reset=0): state=IDLE, acc=0, i=0, result=0, done=0; any run is aborted.
//   States: IDLE, CHECK, MULT, DONE.
//   IDLE: go_i=1 -> acc<=1, i<=1, state<=CHECK. Otherwise hold.
//   CHECK: i>N_MAX -> DONE; i odd -> i<=i+1, stay CHECK;
//     i even -> load multiplier (a=acc, b=i), state<=MULT.
//   MULT: exactly IW cycles of shift-add (LSB-first over b; partial product
//     truncated to W bits). On the last cycle: acc<=product, i<=i+1, state<=CHECK.
//   DONE: done=1, result frozen. go_i=1 -> restart exactly as from IDLE (done drops next edge).
//   go_i while in CHECK or MULT is ignored.
//   result = acc at all times, so intermediate products are visible each cycle.
//   Arithmetic: unsigned; overflow wraps mod 2**W without any flag.
//   N_MAX<2: no multiply occurs; result=1.
//   Latency (edge sampling go_i = edge 0): edges to DONE = 1 + (#odd i) + 9*(#even i)
//     for IW=8; N_MAX=12 -> done high after edge 61, result 46080 (0xB400).
//   Reset mid-MULT: outputs return to reset values immediately; next go_i starts afresh.
// STRUCTURE
//   Package even_mult_pkg: state enum (IDLE,CHECK,MULT,DONE), default W/IW constants.
//   Sub-module shift_add_mult: start/busy/done, a[W], b[IW] -> p[W] truncated,
//     IW cycles per operation. Top holds FSM, acc and i registers.
// TESTING
//   1) reset=0 held 2 cycles, go_i=0 -> result=0, done=0 throughout.
//   2) Release reset, 1-cycle go_i, N_MAX=12 -> done=1 after edge 61, result=46080, then held.
//   3) N_MAX=14 -> result=55296 (645120 mod 65536), wraps silently.
//   4) N_MAX=1 -> done after edge 2 (CHECK i=1, CHECK i=2>1), result=1.
//   5) go_i pulses during MULT -> ignored; final result and latency unchanged.
//   6) reset=0 mid-MULT -> result=0, done=0 immediately; new go_i -> 46080 again;
//      go_i in DONE -> done drops, rerun gives 46080.

Source files
------------

// File: rtl/even_mult_pkg.sv
// -----------------------------------------------------------------------------
// even_mult_pkg
//   Shared definitions for the even-product processor:
//     - state_t : controller states (IDLE, CHECK, MULT, DONE)
//     - W_DEF   : default accumulator/result width
//     - IW_DEF  : default loop-index width (also shift-add cycles per multiply)
// -----------------------------------------------------------------------------
package even_mult_pkg;

    localparam int W_DEF  = 16;
    localparam int IW_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        MULT  = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/even_mult_shift_add_mult.sv
// -----------------------------------------------------------------------------
// shift_add_mult
//   Sequential unsigned multiplier, LSB-first over b. A start pulse loads the
//   operands; the unit is then busy for exactly IW cycles. On the last busy
//   cycle done=1 and p carries the finished product (truncated to W bits), so
//   the caller can capture it on that same edge.
// Ports
//   clk    in   1   rising-edge clock
//   reset  in   1   asynchronous, active-low
//   start  in   1   load a/b and begin (ignored by caller while busy)
//   a      in   W   multiplicand
//   b      in   IW  multiplier
//   busy   out  1   operation in progress
//   done   out  1   last shift-add cycle; p is the final product
//   p      out  W   running partial product including the current step
// -----------------------------------------------------------------------------
module shift_add_mult #(
    parameter int W  = 16,
    parameter int IW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [W-1:0]  a,
    input  logic [IW-1:0] b,
    output logic          busy,
    output logic          done,
    output logic [W-1:0]  p
);

    localparam int CW = (IW > 1) ? $clog2(IW) : 1;

    logic [W-1:0]  a_sh;
    logic [IW-1:0] b_sh;
    logic [W-1:0]  p_acc;
    logic [W-1:0]  p_next;
    logic [CW-1:0] cnt;
    logic          busy_r;

    // Shifting a left inside a W-bit register discards high bits, which is
    // exactly the modulo 2**W truncation of the product.
    always_comb begin
        p_next = p_acc;
        if (b_sh[0]) begin
            p_next = p_acc + a_sh;
        end
    end

    assign busy = busy_r;
    assign done = busy_r && (cnt == CW'(IW - 1));
    assign p    = p_next;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_sh   <= '0;
            b_sh   <= '0;
            p_acc  <= '0;
            cnt    <= '0;
            busy_r <= 1'b0;
        end else if (start) begin
            a_sh   <= a;
            b_sh   <= b;
            p_acc  <= '0;
            cnt    <= '0;
            busy_r <= 1'b1;
        end else if (busy_r) begin
            a_sh  <= a_sh << 1;
            b_sh  <= b_sh >> 1;
            p_acc <= p_next;
            cnt   <= cnt + 1'b1;
            if (done) begin
                busy_r <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/even_mult.sv
// -----------------------------------------------------------------------------
// even_mult
//   Single-purpose processor computing 2*4*...*N_MAX (mod 2**W) with a
//   controller FSM, acc/i registers and a sequential shift-add multiplier.
//   Handshake: go_i is a level sampled on each rising edge and only acted on
//   in IDLE or DONE; done is a registered flag that is high exactly while the
//   FSM sits in DONE, and result (= acc) holds the final product there.
// Ports
//   clk        in   1   rising-edge clock
//   reset      in   1   asynchronous, active-low
//   go_i       in   1   start request
//   result     out  W   accumulator contents (intermediate products visible)
//   done       out  1   run complete, result valid
//   dbg_state  out  2   current controller state for checkers
// -----------------------------------------------------------------------------
module even_mult
    import even_mult_pkg::*;
#(
    parameter int N_MAX = 12,
    parameter int W     = W_DEF,
    parameter int IW    = IW_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         go_i,
    output logic [W-1:0] result,
    output logic         done,
    output state_t       dbg_state
);

    localparam logic [IW-1:0] NMAX_V = IW'(N_MAX);

    state_t        state, state_n;
    logic [W-1:0]  acc, acc_n;
    logic [IW-1:0] i, i_n;
    logic          done_r;

    logic          mul_start;
    logic          mul_busy;
    logic          mul_done;
    logic [W-1:0]  mul_p;

    shift_add_mult #(
        .W  (W),
        .IW (IW)
    ) u_mult (
        .clk   (clk),
        .reset (reset),
        .start (mul_start),
        .a     (acc),
        .b     (i),
        .busy  (mul_busy),
        .done  (mul_done),
        .p     (mul_p)
    );

    always_comb begin
        state_n   = state;
        acc_n     = acc;
        i_n       = i;
        mul_start = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (go_i) begin
                    acc_n   = W'(1);
                    i_n     = IW'(1);
                    state_n = CHECK;
                end
            end
            CHECK: begin
                if (i > NMAX_V) begin
                    state_n = DONE;
                end else if (i[0]) begin
                    i_n = i + 1'b1;
                end else begin
                    mul_start = 1'b1;
                    state_n   = MULT;
                end
            end
            MULT: begin
                // Product is captured on the multiplier's final cycle, so a
                // multiply costs exactly IW cycles in this state.
                if (mul_busy && mul_done) begin
                    acc_n   = mul_p;
                    i_n     = i + 1'b1;
                    state_n = CHECK;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            acc    <= '0;
            i      <= '0;
            done_r <= 1'b0;
        end else begin
            state  <= state_n;
            acc    <= acc_n;
            i      <= i_n;
            done_r <= (state_n == DONE);
        end
    end

    assign result    = acc;
    assign done      = done_r;
    assign dbg_state = state;

endmodule

// File: tb/tb_even_mult.sv
module tb_even_mult;
    import even_mult_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk;
    logic reset;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Three instances: N_MAX = 12, 14 (wraps), 1 (no multiply)
    logic         go  [3];
    logic [15:0]  res [3];
    logic         dn  [3];
    state_t       st  [3];

    even_mult #(.N_MAX(12), .W(16), .IW(8)) dut12 (
        .clk(clk), .reset(reset), .go_i(go[0]), .result(res[0]), .done(dn[0]), .dbg_state(st[0]));
    even_mult #(.N_MAX(14), .W(16), .IW(8)) dut14 (
        .clk(clk), .reset(reset), .go_i(go[1]), .result(res[1]), .done(dn[1]), .dbg_state(st[1]));
    even_mult #(.N_MAX(1), .W(16), .IW(8)) dut1 (
        .clk(clk), .reset(reset), .go_i(go[2]), .result(res[2]), .done(dn[2]), .dbg_state(st[2]));

    int vectors    = 0;
    int miscompares = 0;

    // ---------------- reference model ----------------
    // Expected result/done after each edge, starting with the edge that samples go.
    logic [15:0] exp_q   [$];
    logic        exp_d_q [$];

    task automatic build_model(input int nmax);
        int unsigned acc;
        exp_q.delete();
        exp_d_q.delete();
        acc = 1;
        exp_q.push_back(16'(acc)); exp_d_q.push_back(1'b0);
        for (int n = 1; n <= nmax; n++) begin
            if (n % 2 == 1) begin
                exp_q.push_back(16'(acc)); exp_d_q.push_back(1'b0);
            end else begin
                // one decision cycle plus 8 multiply cycles; product lands on the last
                for (int c = 0; c < 8; c++) begin
                    exp_q.push_back(16'(acc)); exp_d_q.push_back(1'b0);
                end
                acc = (acc * n) % 65536;
                exp_q.push_back(16'(acc)); exp_d_q.push_back(1'b0);
            end
        end
        // final bound check moves to DONE
        exp_q.push_back(16'(acc)); exp_d_q.push_back(1'b1);
    endtask

    // ---------------- driver / checker tasks ----------------
    task automatic run_check(input int k, input int nmax, input bit noise, input string tag);
        logic [15:0] final_v;
        build_model(nmax);
        final_v = exp_q[exp_q.size()-1];
        @(negedge clk);
        go[k] = 1'b1;
        for (int e = 0; e < exp_q.size(); e++) begin
            @(posedge clk);
            #1;
            vectors++;
            if (res[k] !== exp_q[e] || dn[k] !== exp_d_q[e]) begin
                miscompares++;
                $display("FAIL %s edge %0d: result=%h done=%b, expected result=%h done=%b",
                         tag, e, res[k], dn[k], exp_q[e], exp_d_q[e]);
            end
            @(negedge clk);
            if (noise && e < exp_q.size() - 1)
                go[k] = 1'($urandom_range(0, 1));
            else
                go[k] = 1'b0;
        end
        for (int h = 0; h < 3; h++) begin
            @(posedge clk);
            #1;
            vectors++;
            if (res[k] !== final_v || dn[k] !== 1'b1) begin
                miscompares++;
                $display("FAIL %s_hold cycle %0d: result=%h done=%b, expected result=%h done=1",
                         tag, h, res[k], dn[k], final_v);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int k = 0; k < 3; k++) go[k] = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #1;
            for (int k = 0; k < 3; k++) begin
                vectors++;
                if (res[k] !== 16'd0 || dn[k] !== 1'b0) begin
                    miscompares++;
                    $display("FAIL reset inst%0d cycle %0d: result=%h done=%b, expected result=0000 done=0",
                             k, c, res[k], dn[k]);
                end
            end
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_n12();
        run_check(0, 12, 1'b0, "n12");
        vectors++;
        if (res[0] !== 16'd46080) begin
            miscompares++;
            $display("FAIL n12_value: result=%0d, expected 46080", res[0]);
        end
    endtask

    task automatic test_wrap();
        run_check(1, 14, 1'b0, "n14_wrap");
        vectors++;
        if (res[1] !== 16'd55296) begin
            miscompares++;
            $display("FAIL n14_value: result=%0d, expected 55296", res[1]);
        end
    endtask

    task automatic test_small();
        run_check(2, 1, 1'b0, "n1");
    endtask

    task automatic test_go_noise();
        // restart from DONE with random go activity during the run
        for (int r = 0; r < 3; r++) run_check(0, 12, 1'b1, "n12_noise");
        run_check(1, 14, 1'b1, "n14_noise");
    endtask

    task automatic test_reset_mid_mult();
        int w;
        for (int r = 0; r < 2; r++) begin
            w = int'($urandom_range(2, 9));  // lands inside the first multiply
            @(negedge clk);
            go[0] = 1'b1;
            @(posedge clk);
            @(negedge clk);
            go[0] = 1'b0;
            repeat (w) @(posedge clk);
            #3;
            reset = 1'b0;
            #1;
            for (int k = 0; k < 3; k++) begin
                vectors++;
                if (res[k] !== 16'd0 || dn[k] !== 1'b0) begin
                    miscompares++;
                    $display("FAIL async_reset inst%0d: result=%h done=%b, expected result=0000 done=0",
                             k, res[k], dn[k]);
                end
            end
            @(posedge clk);
            #1;
            vectors++;
            if (res[0] !== 16'd0 || dn[0] !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_held: result=%h done=%b, expected result=0000 done=0", res[0], dn[0]);
            end
            @(negedge clk);
            reset = 1'b1;
            run_check(0, 12, 1'b0, "after_reset");
        end
    endtask

    task automatic test_back_to_back();
        // go asserted the very cycle after DONE is observed
        run_check(0, 12, 1'b0, "b2b_a");
        run_check(0, 12, 1'b0, "b2b_b");
        run_check(2, 1, 1'b0, "b2b_n1");
    endtask

    initial begin
        for (int k = 0; k < 3; k++) go[k] = 1'b0;
        reset = 1'b0;
        test_reset();
        test_n12();
        test_wrap();
        test_small();
        test_go_noise();
        test_reset_mid_mult();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
